// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command-issue stage.
//   ALU_W / ALU_SEL_W : operand/result width and opcode width of the ALU
//   alu_cmd_t         : one buffered command {a, b, sel, use_acc}
//   issue_state_e     : issue FSM states
package alu_pkg;

  localparam int ALU_W     = 16;
  localparam int ALU_SEL_W = 3;

  typedef struct packed {
    logic [ALU_W-1:0]     a;
    logic [ALU_W-1:0]     b;
    logic [ALU_SEL_W-1:0] sel;
    logic                 use_acc;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_cmd_issue_if.sv
// Bus bundle between the command producer / result consumer / ALU and the
// issue stage.
//   cmd_*   : command channel (producer -> issue stage)
//   alu_*   : registered ALU operands out, combinational ALU result in
//   res_*   : result channel (issue stage -> consumer), res_zero = res_data==0
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. The source keeps valid and its payload
// stable until that edge; ready may change freely and is never a function of
// valid on the same side.
// Modports: master = producer/consumer/ALU side, slave = issue stage.
interface alu_cmd_issue_if
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int SEL_W = ALU_SEL_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic [SEL_W-1:0] cmd_sel;
  logic             cmd_use_acc;

  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [W-1:0]     alu_out;

  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_data;
  logic [SEL_W-1:0] res_sel;
  logic             res_zero;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc, alu_out, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel, res_zero
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc, alu_out, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel, res_zero
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO of alu_cmd_t.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   push       : write push_data at the tail (ignored when full)
//   pop        : advance the head (ignored when empty)
//   pop_data   : current head entry
//   level      : occupancy 0..DEPTH
//   full/empty : level == DEPTH / level == 0
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  alu_cmd_t                 push_data,
  input  logic                     pop,
  output alu_cmd_t                 pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of a 16-bit combinational ALU.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command / ALU / result channels (slave side)
//   level      : command FIFO occupancy
//   dbg_state  : current issue FSM state
// Commands are buffered, popped into the alu_a/alu_b/alu_sel registers,
// given one full cycle in the ALU (EXEC), then the ALU output is held in the
// result register until the consumer takes it (RESULT). The last result is
// also kept in an accumulator that a use_acc command substitutes for operand A.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_cmd_issue_if.slave         bus,
  output logic [$clog2(DEPTH):0] level,
  output issue_state_e           dbg_state
);

  issue_state_e     state;
  issue_state_e     state_next;
  logic             pop;
  logic             capture;

  alu_cmd_t         push_cmd;
  alu_cmd_t         head;
  logic             fifo_full;
  logic             fifo_empty;

  logic [W-1:0]     acc;
  logic [W-1:0]     alu_a_q;
  logic [W-1:0]     alu_b_q;
  logic [SEL_W-1:0] alu_sel_q;
  logic [W-1:0]     res_data_q;
  logic [SEL_W-1:0] res_sel_q;

  assign push_cmd.a       = bus.cmd_a;
  assign push_cmd.b       = bus.cmd_b;
  assign push_cmd.sel     = bus.cmd_sel;
  assign push_cmd.use_acc = bus.cmd_use_acc;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.cmd_ready = !fifo_full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  // A result is on offer exactly while the FSM sits in RESULT.
  assign bus.res_valid = (state == RESULT);
  assign bus.res_data  = res_data_q;
  assign bus.res_sel   = res_sel_q;
  assign bus.res_zero  = (res_data_q == '0);
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Leaving RESULT with work queued goes straight to EXEC, which is what
  // gives one result every two cycles under continuous res_ready.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESULT;
      end
      RESULT: begin
        if (bus.res_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // acc is written in EXEC and read at the next pop, which is never earlier
  // than the following edge, so a use_acc command always sees its direct
  // predecessor's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      res_data_q <= '0;
      res_sel_q  <= '0;
    end else begin
      if (pop) begin
        alu_a_q   <= head.use_acc ? acc : head.a;
        alu_b_q   <= head.b;
        alu_sel_q <= head.sel;
      end
      if (capture) begin
        res_data_q <= bus.alu_out;
        res_sel_q  <= alu_sel_q;
        acc        <= bus.alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic [$clog2(DEPTH):0] level;
  issue_state_e           dbg_state;

  alu_cmd_issue_if #(.W(ALU_W), .SEL_W(ALU_SEL_W)) bus ();

  alu_cmd_issue #(.DEPTH(DEPTH), .W(ALU_W), .SEL_W(ALU_SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .level     (level),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stub ALU ----------------
  always_comb begin
    case (bus.alu_sel)
      3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
      default: bus.alu_out = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int                              checks;
  int                              errors;
  logic [ALU_W-1:0]                model_acc;
  logic [ALU_SEL_W+ALU_W-1:0]      exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [ALU_W-1:0] a, input logic [ALU_W-1:0] b,
                            input logic [ALU_SEL_W-1:0] sel, input logic ua);
    logic [ALU_W-1:0] op_a;
    logic [ALU_W-1:0] r;
    op_a = ua ? model_acc : a;
    case (sel)
      3'b000:  r = op_a + b;
      3'b001:  r = op_a - b;
      default: r = '0;
    endcase
    model_acc = r;
    exp_q.push_back({sel, r});
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_cmd(input logic [ALU_W-1:0] a, input logic [ALU_W-1:0] b,
                           input logic [ALU_SEL_W-1:0] sel, input logic ua);
    bus.cmd_valid   = 1'b1;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_sel     = sel;
    bus.cmd_use_acc = ua;
  endtask

  task automatic send(input logic [ALU_W-1:0] a, input logic [ALU_W-1:0] b,
                      input logic [ALU_SEL_W-1:0] sel, input logic ua);
    int n;
    n = 0;
    drive_cmd(a, b, sel, ua);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
    end else begin
      model_push(a, b, sel, ua);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic take_result(output int waited);
    logic [ALU_SEL_W+ALU_W-1:0] e;
    int n;
    n = 0;
    bus.res_ready = 1'b1;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!bus.res_valid) begin
      check("res_valid_timeout", 32'(bus.res_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      check("unexpected_result", 32'(bus.res_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("res_data", 32'(bus.res_data), 32'(e[ALU_W-1:0]));
      check("res_sel", 32'(bus.res_sel), 32'(e[ALU_SEL_W+ALU_W-1:ALU_W]));
      check("res_zero", 32'(bus.res_zero), 32'(e[ALU_W-1:0] == '0));
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string phase);
    check({phase, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({phase, "_alu_a"}, 32'(bus.alu_a), 32'd0);
    check({phase, "_alu_b"}, 32'(bus.alu_b), 32'd0);
    check({phase, "_alu_sel"}, 32'(bus.alu_sel), 32'd0);
    check({phase, "_level"}, 32'(level), 32'd0);
    check({phase, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({phase, "_res_zero"}, 32'(bus.res_zero), 32'd1);
    check({phase, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int accepted;
    logic [ALU_W-1:0]           ra;
    logic [ALU_W-1:0]           rb;
    logic [ALU_SEL_W-1:0]       rs;
    logic [ALU_SEL_W+ALU_W-1:0] e;

    checks          = 0;
    errors          = 0;
    model_acc       = '0;
    rst_n           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_a       = '0;
    bus.cmd_b       = '0;
    bus.cmd_sel     = '0;
    bus.cmd_use_acc = 1'b0;
    bus.res_ready   = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single command: 9 + 1.
    send(16'h0009, 16'h0001, 3'b000, 1'b0);
    @(negedge clk);
    check("e1_alu_a", 32'(bus.alu_a), 32'h0009);
    check("e1_alu_b", 32'(bus.alu_b), 32'h0001);
    check("e1_alu_sel", 32'(bus.alu_sel), 32'd0);
    check("e1_res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check("e2_res_valid", 32'(bus.res_valid), 32'd1);
    take_result(w);
    check("single_wait", 32'(w), 32'd0);

    // Accumulator chain: acc(0xA) - 0xA = 0.
    send(16'h0000, 16'h000A, 3'b001, 1'b1);
    @(negedge clk);
    check("chain_alu_a", 32'(bus.alu_a), 32'h000A);
    check("chain_alu_sel", 32'(bus.alu_sel), 32'd1);
    take_result(w);

    // Fill under backpressure: 6 offered, 5 accepted.
    bus.res_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rs = 3'($urandom_range(0, 1));
      drive_cmd(ra, rb, rs, i == 2);
      if (bus.cmd_ready) begin
        model_push(ra, rb, rs, i == 2);
        accepted++;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("fill_accepted", 32'(accepted), 32'd5);
    check("fill_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("fill_level", 32'(level), 32'd4);
    e = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      check("stall_res_valid", 32'(bus.res_valid), 32'd1);
      check("stall_res_data", 32'(bus.res_data), 32'(e[ALU_W-1:0]));
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      take_result(w);
      check("drain_gap", 32'(w), (i == 0) ? 32'd0 : 32'd1);
    end
    check("drain_empty_level", 32'(level), 32'd0);

    // Simultaneous push and pop at level 2.
    send(16'h0100, 16'h0001, 3'b000, 1'b0);
    send(16'h0000, 16'h0010, 3'b000, 1'b1);
    send(16'h0050, 16'h0020, 3'b001, 1'b0);
    check("pp_level_before", 32'(level), 32'd2);
    check("pp_res_valid", 32'(bus.res_valid), 32'd1);
    e = exp_q.pop_front();
    check("pp_res_data", 32'(bus.res_data), 32'(e[ALU_W-1:0]));
    bus.res_ready = 1'b1;
    drive_cmd(16'h0000, 16'h0003, 3'b001, 1'b1);
    check("pp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    model_push(16'h0000, 16'h0003, 3'b001, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("pp_level_after", 32'(level), 32'd2);
    for (int i = 0; i < 3; i++) take_result(w);

    // Reset mid-operation with level 3 and a pending result.
    send(16'h1111, 16'h0001, 3'b000, 1'b0);
    send(16'h2222, 16'h0002, 3'b000, 1'b0);
    send(16'h3333, 16'h0003, 3'b000, 1'b0);
    send(16'h4444, 16'h0004, 3'b000, 1'b0);
    check("mid_level", 32'(level), 32'd3);
    check("mid_res_valid", 32'(bus.res_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("mid");
    exp_q.delete();
    model_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_result", 32'(bus.res_valid), 32'd0);
    end
    bus.res_ready = 1'b0;
    // use_acc right after reset must see 0: 0 + 5.
    send(16'h1234, 16'h0005, 3'b000, 1'b1);
    take_result(w);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
